// File: rtl/led_register_bank_pkg.sv
// Shared address map constants and reset defaults for the LED register bank.
package led_register_bank_pkg;

    localparam int MAX_CH = 16;

    typedef enum logic [1:0] {
        BYTE_ON_L  = 2'd0,
        BYTE_ON_H  = 2'd1,
        BYTE_OFF_L = 2'd2,
        BYTE_OFF_H = 2'd3
    } led_byte_e;

    localparam logic [7:0] ADDR_CTRL0     = 8'h00;
    localparam logic [7:0] ADDR_CTRL1     = 8'h01;
    localparam logic [7:0] ADDR_CTRL_FE   = 8'hFE;
    localparam logic [7:0] ADDR_CTRL_FF   = 8'hFF;
    localparam logic [7:0] ADDR_ALL_LED   = 8'hFA;

    localparam logic [7:0] DEF_CTRL0      = 8'h11;
    localparam logic [7:0] DEF_CTRL1      = 8'h04;
    localparam logic [7:0] DEF_CTRL_FE    = 8'h1E;

    function automatic logic [7:0] ctrl_default(input logic [7:0] addr);
        case (addr)
            ADDR_CTRL0:   return DEF_CTRL0;
            ADDR_CTRL1:   return DEF_CTRL1;
            ADDR_CTRL_FE: return DEF_CTRL_FE;
            default:      return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/led_register_bank_shadow.sv
// One LED channel: working bytes with per-byte dirty bits and the committed value.
module led_channel_shadow
    import led_register_bank_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        commit_mode_i,
    input  logic        stop_i,
    input  logic [3:0]  byte_we_i,
    input  logic [7:0]  wr_data_i,
    output logic [31:0] work_o,
    output logic [31:0] led_o,
    output logic        commit_o
);

    logic [31:0] work_q;
    logic [3:0]  dirty_q;
    logic [31:0] led_q;
    logic        commit_q;
    logic        do_commit;

    // Decided on the dirty state before this edge's write lands.
    assign do_commit = commit_mode_i ? (stop_i && (dirty_q != 4'b0000)) : (dirty_q == 4'b1111);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            work_q   <= '0;
            dirty_q  <= '0;
            led_q    <= '0;
            commit_q <= 1'b0;
        end else begin
            commit_q <= do_commit;
            for (int k = 0; k < 4; k++) begin
                if (byte_we_i[k]) work_q[8*k +: 8] <= wr_data_i;
            end
            if (do_commit) begin
                led_q   <= work_q;
                dirty_q <= byte_we_i;
            end else begin
                dirty_q <= dirty_q | byte_we_i;
            end
        end
    end

    assign work_o   = work_q;
    assign led_o    = led_q;
    assign commit_o = commit_q;

endmodule

// File: rtl/led_register_bank.sv
// Byte-addressed LED register bank: control registers, per-channel shadows, registered read port.
module led_register_bank
    import led_register_bank_pkg::*;
#(
    parameter int         NUM_CH   = 16,
    parameter logic [7:0] LED_BASE = 8'h06
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [7:0]            wr_addr_i,
    input  logic [7:0]            wr_data_i,
    input  logic                  rd_en_i,
    input  logic [7:0]            rd_addr_i,
    output logic [7:0]            rd_data_o,
    output logic                  rd_valid_o,
    input  logic                  commit_mode_i,
    input  logic                  stop_i,
    output logic [NUM_CH*32-1:0]  led_o,
    output logic [NUM_CH-1:0]     commit_o
);

    localparam int CTRL_LO = int'(LED_BASE);
    localparam int CTRL_N  = CTRL_LO + 2;

    // Control slots 0..LED_BASE-1 map straight to addresses; the last two are 0xFE/0xFF.
    function automatic logic [7:0] ctrl_addr(input int i);
        if (i < CTRL_LO)  return 8'(i);
        if (i == CTRL_LO) return ADDR_CTRL_FE;
        return ADDR_CTRL_FF;
    endfunction

    logic [7:0]  ctrl_q [CTRL_N];
    logic [31:0] work [NUM_CH];
    logic [7:0]  rd_byte;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < CTRL_N; i++) ctrl_q[i] <= ctrl_default(ctrl_addr(i));
        end else if (wr_en_i) begin
            for (int i = 0; i < CTRL_N; i++) begin
                if (wr_addr_i == ctrl_addr(i)) ctrl_q[i] <= wr_data_i;
            end
        end
    end

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        logic [3:0] be;
        for (genvar k = 0; k < 4; k++) begin : g_byte
            assign be[k] = wr_en_i &&
                           ((wr_addr_i == 8'(CTRL_LO + 4*n + k)) ||
                            (wr_addr_i == 8'(int'(ADDR_ALL_LED) + k)));
        end

        led_channel_shadow u_shadow (
            .clk_i         (clk_i),
            .rst_i         (rst_i),
            .commit_mode_i (commit_mode_i),
            .stop_i        (stop_i),
            .byte_we_i     (be),
            .wr_data_i     (wr_data_i),
            .work_o        (work[n]),
            .led_o         (led_o[32*n +: 32]),
            .commit_o      (commit_o[n])
        );
    end

    // ALL_LED and unmapped addresses fall through to zero.
    always_comb begin
        rd_byte = 8'h00;
        for (int i = 0; i < CTRL_N; i++) begin
            if (rd_addr_i == ctrl_addr(i)) rd_byte = ctrl_q[i];
        end
        for (int n = 0; n < NUM_CH; n++) begin
            for (int k = 0; k < 4; k++) begin
                if (rd_addr_i == 8'(CTRL_LO + 4*n + k)) rd_byte = work[n][8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_valid_o <= 1'b0;
            rd_data_o  <= 8'h00;
        end else begin
            rd_valid_o <= rd_en_i;
            if (rd_en_i) rd_data_o <= rd_byte;
        end
    end

endmodule

// File: tb/tb_led_register_bank.sv
// Scoreboard bench for led_register_bank: random and directed traffic against a byte-level model.
module tb_led_register_bank;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         wr_en = 1'b0;
    logic [7:0]   wr_addr = 8'h00;
    logic [7:0]   wr_data = 8'h00;
    logic         rd_en = 1'b0;
    logic [7:0]   rd_addr = 8'h00;
    logic         mode = 1'b0;
    logic         stop = 1'b0;

    logic [7:0]   rd_data;
    logic         rd_valid;
    logic [511:0] led;
    logic [15:0]  commit;

    logic [7:0]   rd_data4;
    logic         rd_valid4;
    logic [127:0] led4;
    logic [3:0]   commit4;

    always #5 clk = ~clk;

    led_register_bank #(.NUM_CH(16), .LED_BASE(8'h06)) dut (
        .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_valid_o(rd_valid),
        .commit_mode_i(mode), .stop_i(stop), .led_o(led), .commit_o(commit)
    );

    led_register_bank #(.NUM_CH(4), .LED_BASE(8'h06)) dut4 (
        .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data4), .rd_valid_o(rd_valid4),
        .commit_mode_i(mode), .stop_i(stop), .led_o(led4), .commit_o(commit4)
    );

    typedef struct { int edge_n; logic [7:0] data; } rd_exp_t;
    typedef struct { int edge_n; logic [15:0] vec; logic [511:0] leds; } cm_exp_t;

    rd_exp_t rd_q[$];
    cm_exp_t cm_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int edge_no = 0;

    // Reference model: plain byte arrays indexed by channel and byte number.
    logic [7:0]  m_work [16][4];
    bit          m_dirty [16][4];
    logic [31:0] m_led [16];
    logic [7:0]  m_ctrl [256];

    function automatic void check(string nm, logic [511:0] act, logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic bit is_ctrl(logic [7:0] a);
        return (a < 8'h06) || (a >= 8'hFE);
    endfunction

    function automatic bit is_chan(logic [7:0] a);
        return (a >= 8'h06) && (a < 8'h46);
    endfunction

    function automatic logic [7:0] m_read(logic [7:0] a);
        int off;
        off = int'(a) - 6;
        if (is_ctrl(a)) return m_ctrl[a];
        if (is_chan(a)) return m_work[4'(off / 4)][2'(off % 4)];
        return 8'h00;
    endfunction

    function automatic logic [511:0] m_leds();
        logic [511:0] v;
        for (int c = 0; c < 16; c++) v[32*c +: 32] = m_led[c];
        return v;
    endfunction

    task automatic model_reset();
        for (int a = 0; a < 256; a++) m_ctrl[a] = 8'h00;
        m_ctrl[8'h00] = 8'h11;
        m_ctrl[8'h01] = 8'h04;
        m_ctrl[8'hFE] = 8'h1E;
        for (int c = 0; c < 16; c++) begin
            m_led[c] = 32'h0;
            for (int k = 0; k < 4; k++) begin
                m_work[c][k] = 8'h00;
                m_dirty[c][k] = 1'b0;
            end
        end
    endtask

    // One clock: drive inputs, advance the model across the coming edge, return at the negedge.
    task automatic step(input bit r, input bit we, input logic [7:0] wa, input logic [7:0] wd,
                        input bit re, input logic [7:0] ra, input bit md, input bit st);
        logic [15:0] vec;
        int off;
        bit all_d, any_d;
        rst = r; wr_en = we; wr_addr = wa; wr_data = wd;
        rd_en = re; rd_addr = ra; mode = md; stop = st;
        if (r) begin
            model_reset();
        end else begin
            if (re) rd_q.push_back('{edge_no + 1, m_read(ra)});
            vec = '0;
            for (int c = 0; c < 16; c++) begin
                all_d = 1'b1; any_d = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    all_d &= m_dirty[c][k];
                    any_d |= m_dirty[c][k];
                end
                if (md ? (st && any_d) : all_d) begin
                    vec[c] = 1'b1;
                    m_led[c] = {m_work[c][3], m_work[c][2], m_work[c][1], m_work[c][0]};
                    for (int k = 0; k < 4; k++) m_dirty[c][k] = 1'b0;
                end
            end
            if (we) begin
                off = int'(wa) - 6;
                if (is_ctrl(wa)) begin
                    m_ctrl[wa] = wd;
                end else if (is_chan(wa)) begin
                    m_work[4'(off / 4)][2'(off % 4)] = wd;
                    m_dirty[4'(off / 4)][2'(off % 4)] = 1'b1;
                end else if (wa >= 8'hFA && wa <= 8'hFD) begin
                    for (int c = 0; c < 16; c++) begin
                        m_work[c][2'(wa - 8'hFA)] = wd;
                        m_dirty[c][2'(wa - 8'hFA)] = 1'b1;
                    end
                end
            end
            if (vec != 0) cm_q.push_back('{edge_no + 1, vec, m_leds()});
        end
        @(posedge clk);
        edge_no++;
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit md);
        for (int i = 0; i < n; i++) step(0, 0, 8'h00, 8'h00, 0, 8'h00, md, 0);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d, input bit md);
        step(0, 1, a, d, 0, 8'h00, md, 0);
    endtask

    task automatic rd(input logic [7:0] a, input bit md);
        step(0, 0, 8'h00, 8'h00, 1, a, md, 0);
    endtask

    // Monitor: pops expectations whenever the DUT presents read data or a commit pulse.
    always @(negedge clk) begin
        rd_exp_t re;
        cm_exp_t ce;
        if (rd_valid === 1'b1) begin
            if (rd_q.size() == 0) begin
                check("rd_unexpected", 512'(rd_data), 512'(0));
                check("rd_unexpected_valid", 512'(rd_valid), 512'(0));
            end else begin
                re = rd_q.pop_front();
                check("rd_edge", 512'(edge_no), 512'(re.edge_n));
                check("rd_data", 512'(rd_data), 512'(re.data));
            end
        end else if (rd_q.size() != 0 && rd_q[0].edge_n <= edge_no) begin
            re = rd_q.pop_front();
            check("rd_missing_valid", 512'(rd_valid), 512'(1));
        end
        if (commit !== 16'h0 && commit !== 16'hx) begin
            if (cm_q.size() == 0) begin
                check("commit_unexpected", 512'(commit), 512'(0));
            end else begin
                ce = cm_q.pop_front();
                check("commit_edge", 512'(edge_no), 512'(ce.edge_n));
                check("commit_vec", 512'(commit), 512'(ce.vec));
                check("commit_led", led, ce.leds);
            end
        end else if (cm_q.size() != 0 && cm_q[0].edge_n <= edge_no) begin
            ce = cm_q.pop_front();
            check("commit_missing", 512'(commit), 512'(ce.vec));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit cur_mode;
        int sel;
        logic [7:0] a, d, ra;
        model_reset();

        step(1, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0);
        step(1, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0);
        check("reset_rd_valid", 512'(rd_valid), 512'(0));
        check("reset_rd_data", 512'(rd_data), 512'(0));
        check("reset_led", led, 512'(0));
        check("reset_commit", 512'(commit), 512'(0));
        check("reset_led4", 512'(led4), 512'(0));
        rd(8'h00, 0); rd(8'h01, 0); rd(8'hFE, 0); rd(8'hFF, 0); rd(8'hFA, 0);

        // Mode 0, channel 0 full write.
        wr(8'h06, 8'h10, 0); wr(8'h07, 8'h00, 0); wr(8'h08, 8'h20, 0); wr(8'h09, 8'h01, 0);
        idle(1, 0);
        check("ch0_commit", 512'(commit[0]), 512'(1));
        check("ch0_led", 512'(led[31:0]), 512'(32'h0120_0010));

        // Mode 0, channel 3 partial write never commits.
        wr(8'h12, 8'h12, 0); wr(8'h13, 8'h13, 0); wr(8'h14, 8'h14, 0);
        idle(20, 0);
        check("ch3_partial_led", 512'(led[127:96]), 512'(0));

        // Mode 1, single byte then stop.
        step(1, 0, 8'h00, 8'h00, 0, 8'h00, 1, 0);
        wr(8'h0D, 8'h10, 1);
        idle(3, 1);
        check("mode1_no_early", 512'(led[63:32]), 512'(0));
        step(0, 0, 8'h00, 8'h00, 0, 8'h00, 1, 1);
        check("mode1_led", 512'(led[63:32]), 512'(32'h1000_0000));
        check("mode1_commit", 512'(commit), 512'(16'h0002));

        // ALL_LED broadcast.
        wr(8'hFA, 8'hFF, 0); wr(8'hFB, 8'hFF, 0); wr(8'hFC, 8'hFF, 0); wr(8'hFD, 8'hFF, 0);
        idle(1, 0);
        check("all_commit", 512'(commit), 512'(16'hFFFF));
        check("all_led", led, {512{1'b1}});
        idle(2, 0);

        // Channel 2: write on its own commit edge.
        wr(8'h0E, 8'hA1, 0); wr(8'h0F, 8'hA2, 0); wr(8'h10, 8'hA3, 0); wr(8'h11, 8'hA4, 0);
        wr(8'h0E, 8'h5A, 0);
        check("ch2_old_bytes", 512'(led[95:64]), 512'(32'hA4A3_A2A1));
        check("ch2_commit", 512'(commit[2]), 512'(1));
        wr(8'h0F, 8'hB2, 0); wr(8'h10, 8'hB3, 0); wr(8'h11, 8'hB4, 0);
        idle(1, 0);
        check("ch2_second", 512'(led[95:64]), 512'(32'hB4B3_B25A));

        // NUM_CH=4 instance: channel 5 address is unmapped there.
        step(1, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0);
        wr(8'h1A, 8'h55, 0);
        rd(8'h1A, 0);
        check("n4_rd_valid", 512'(rd_valid4), 512'(1));
        check("n4_rd_data", 512'(rd_data4), 512'(0));
        idle(2, 0);
        check("n4_led", 512'(led4), 512'(0));
        check("n4_commit", 512'(commit4), 512'(0));

        // Reset mid-sequence discards partial state and control writes.
        wr(8'h00, 8'h77, 0); wr(8'h06, 8'hC0, 0); wr(8'h07, 8'hC1, 0);
        step(1, 0, 8'h00, 8'h00, 0, 8'h00, 0, 0);
        check("midrst_led", led, 512'(0));
        check("midrst_rd_valid", 512'(rd_valid), 512'(0));
        wr(8'h08, 8'hC2, 0); wr(8'h09, 8'hC3, 0);
        idle(3, 0);
        check("midrst_no_commit", 512'(led[31:0]), 512'(0));
        rd(8'h00, 0);
        check("n4_ctrl0", 512'(rd_data4), 512'(8'h11));

        // Randomized traffic.
        cur_mode = 1'b0;
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 39) == 0) cur_mode = ~cur_mode;
            sel = $urandom_range(0, 9);
            if (sel <= 5)      a = 8'($urandom_range(6, 69));
            else if (sel == 6) a = 8'($urandom_range(8'hFA, 8'hFD));
            else if (sel == 7) a = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 5)) : 8'($urandom_range(8'hFE, 8'hFF));
            else               a = 8'($urandom_range(0, 255));
            ra = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 71));
            d = 8'($urandom_range(0, 255));
            step(($urandom_range(0, 149) == 0), ($urandom_range(0, 1) == 1), a, d,
                 ($urandom_range(0, 1) == 1), ra, cur_mode, ($urandom_range(0, 7) == 0));
        end
        idle(3, cur_mode);
        check("final_led", led, m_leds());
        check("rd_queue_empty", 512'(rd_q.size()), 512'(0));
        check("cm_queue_empty", 512'(cm_q.size()), 512'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
